// File: rtl/poly_arith_pkg.sv
// -----------------------------------------------------------------------------
// poly_arith_pkg
// Shared arithmetic definitions for the Kyber/ML-KEM pointwise multiplier:
//   Q           - prime modulus 3329
//   N_PAIRS_DEF - default number of degree-one pairs per polynomial (128)
//   coeff_t     - 12-bit coefficient
//   state_t     - sequencer states
//   GAMMA       - 128-entry constant table, GAMMA[i] = 17^(2*BitRev7(i)+1) mod Q
//   mod_q()     - reduction of a non-negative 25-bit value into [0, Q-1]
// -----------------------------------------------------------------------------
package poly_arith_pkg;

    localparam int unsigned Q           = 3329;
    localparam int          N_PAIRS_DEF = 128;

    typedef logic [11:0] coeff_t;
    typedef logic [N_PAIRS_DEF-1:0][11:0] gamma_tbl_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [6:0] bitrev7(input logic [6:0] x);
        logic [6:0] r;
        for (int j = 0; j < 7; j++) begin
            r[j] = x[6-j];
        end
        return r;
    endfunction

    // Evaluated at elaboration only; the result is a constant ROM image.
    function automatic gamma_tbl_t gen_gamma();
        gamma_tbl_t  t;
        logic [7:0]  e;
        int unsigned acc;
        int unsigned base;
        for (int i = 0; i < N_PAIRS_DEF; i++) begin
            e    = {bitrev7(7'(i)), 1'b1};   // 2*BitRev7(i) + 1
            acc  = 1;
            base = 17;
            for (int k = 0; k < 8; k++) begin
                if (e[k]) begin
                    acc = (acc * base) % Q;
                end
                base = (base * base) % Q;
            end
            t[i] = coeff_t'(acc);
        end
        return t;
    endfunction

    localparam gamma_tbl_t GAMMA = gen_gamma();

    function automatic coeff_t mod_q(input logic [24:0] x);
        return coeff_t'(x % 25'(Q));
    endfunction

endpackage

// File: rtl/base_case_mul.sv
// -----------------------------------------------------------------------------
// base_case_mul
// Four-stage pipelined BaseCaseMultiply over Z_Q[X]/(X^2 - gamma):
//   c0 = a0*b0 + a1*b1*gamma   (mod Q)
//   c1 = a0*b1 + a1*b0         (mod Q)
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears valids only)
//   valid_i    - operands present on a_i/b_i/gamma_i
//   a_i, b_i   - packed pairs {x1[23:12], x0[11:0]}, canonical (< Q)
//   gamma_i    - twiddle for this pair
//   valid_o    - c_o holds a result; exactly 4 cycles after valid_i
//   c_o        - packed result {c1, c0}, each in [0, Q-1]
// -----------------------------------------------------------------------------
module base_case_mul
    import poly_arith_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  coeff_t      gamma_i,
    output logic        valid_o,
    output logic [23:0] c_o
);

    logic [11:0] w_a0, w_a1, w_b0, w_b1;
    assign w_a0 = a_i[11:0];
    assign w_a1 = a_i[23:12];
    assign w_b0 = b_i[11:0];
    assign w_b1 = b_i[23:12];

    logic [3:0]  r_vld;

    // Stage 1: raw products
    logic [23:0] r_p00_1;
    logic [23:0] r_p11_1;
    logic [24:0] r_pm_1;
    coeff_t      r_g_1;
    // Stage 2: a1*b1 reduced, cross term reduced
    logic [23:0] r_p00_2;
    coeff_t      r_r11_2;
    coeff_t      r_c1_2;
    coeff_t      r_g_2;
    // Stage 3: unreduced c0
    logic [24:0] r_t_3;
    coeff_t      r_c1_3;
    // Stage 4: final
    coeff_t      r_c0_4;
    coeff_t      r_c1_4;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[2:0], valid_i};
        end
    end

    // NOTE: the data pipeline has no reset; only the valid shift register
    // is cleared, and downstream logic ignores data without a valid.
    always_ff @(posedge clk) begin
        r_p00_1 <= 24'(w_a0) * 24'(w_b0);
        r_p11_1 <= 24'(w_a1) * 24'(w_b1);
        r_pm_1  <= 25'(w_a0) * 25'(w_b1) + 25'(w_a1) * 25'(w_b0);
        r_g_1   <= gamma_i;

        r_p00_2 <= r_p00_1;
        r_r11_2 <= mod_q({1'b0, r_p11_1});
        r_c1_2  <= mod_q(r_pm_1);
        r_g_2   <= r_g_1;

        // (Q-1)^2 + (Q-1)^2 < 2^25, so the sum cannot overflow.
        r_t_3   <= 25'(r_r11_2) * 25'(r_g_2) + 25'(r_p00_2);
        r_c1_3  <= r_c1_2;

        r_c0_4  <= mod_q(r_t_3);
        r_c1_4  <= r_c1_3;
    end

    assign valid_o = r_vld[3];
    assign c_o     = {r_c1_4, r_c0_4};

endmodule

// File: rtl/poly_pointwise_mul.sv
// -----------------------------------------------------------------------------
// poly_pointwise_mul
// Streams N_PAIRS coefficient pairs from the A and B memories through one
// base_case_mul and writes the products to the C memory.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start_i               - start pulse, honoured only in IDLE
//   busy_o                - high whenever not IDLE
//   done_o                - one-cycle completion pulse
//   rd_en_o, rd_addr_o    - shared read strobe / pair index for A and B
//   a_data_i, b_data_i    - read data, valid one cycle after rd_en_o
//   wr_en_o, wr_addr_o    - C write strobe / pair index
//   wr_data_o             - C pair {c1, c0}
// All outputs are forced to 0 while IDLE.
// -----------------------------------------------------------------------------
module poly_pointwise_mul
    import poly_arith_pkg::*;
#(
    parameter int N_PAIRS = N_PAIRS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        rd_en_o,
    output logic [6:0]  rd_addr_o,
    input  logic [23:0] a_data_i,
    input  logic [23:0] b_data_i,
    output logic        wr_en_o,
    output logic [6:0]  wr_addr_o,
    output logic [23:0] wr_data_o
);

    localparam logic [6:0] LAST = 7'(N_PAIRS - 1);

    state_t      r_state;
    logic [6:0]  r_rd_addr;
    logic [6:0]  r_wr_addr;
    logic        r_rd_vld;     // rd_en_o delayed to line up with read data
    coeff_t      r_gamma;

    logic        w_mul_vld;
    logic [23:0] w_mul_c;

    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = (r_state == S_DONE);
    assign rd_en_o   = (r_state == S_ISSUE);
    assign rd_addr_o = rd_en_o ? r_rd_addr : '0;
    // A mid-run reset clears the in-flight valids; the state gate additionally
    // keeps IDLE silent.
    assign wr_en_o   = w_mul_vld && (r_state != S_IDLE);
    assign wr_addr_o = wr_en_o ? r_wr_addr : '0;
    assign wr_data_o = wr_en_o ? w_mul_c   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= rd_en_o;

            // Saturates at the terminal index; a new start clears it.
            if (wr_en_o && (r_wr_addr != LAST)) begin
                r_wr_addr <= r_wr_addr + 7'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state   <= S_ISSUE;
                        r_rd_addr <= '0;
                        r_wr_addr <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_rd_addr == LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + 7'd1;
                    end
                end
                S_DRAIN: begin
                    if (wr_en_o && (r_wr_addr == LAST)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Twiddle lookup registered once so it meets the read data at the multiplier.
    always_ff @(posedge clk) begin
        r_gamma <= GAMMA[r_rd_addr];
    end

    base_case_mul u_base_case_mul (
        .clk     (clk),
        .rst     (rst),
        .valid_i (r_rd_vld),
        .a_i     (a_data_i),
        .b_i     (b_data_i),
        .gamma_i (r_gamma),
        .valid_o (w_mul_vld),
        .c_o     (w_mul_c)
    );

endmodule

// File: tb/tb_poly_pointwise_mul.sv
// -----------------------------------------------------------------------------
// tb_poly_pointwise_mul
// Self-checking bench for poly_pointwise_mul. A behavioural A/B memory answers
// read strobes; every read pushes the mathematically expected C pair onto a
// scoreboard queue, and every write pops and compares it. Scenario tasks also
// check cycle timing and selected C entries against literal values.
// -----------------------------------------------------------------------------
module tb_poly_pointwise_mul;

    localparam int N = 128;
    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        rd_en_o;
    logic [6:0]  rd_addr_o;
    logic [23:0] a_data_i = '0;
    logic [23:0] b_data_i = '0;
    logic        wr_en_o;
    logic [6:0]  wr_addr_o;
    logic [23:0] wr_data_o;

    always #5 clk = ~clk;

    poly_pointwise_mul #(.N_PAIRS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .a_data_i  (a_data_i),
        .b_data_i  (b_data_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
    );

    logic [23:0] mem_a [N];
    logic [23:0] mem_b [N];
    logic [23:0] c_out [N];
    int          gamma_ref [N];

    typedef struct packed {
        logic [6:0]  addr;
        logic [23:0] data;
    } sb_t;
    sb_t sb[$];

    int checks = 0;
    int errors = 0;

    // Synchronous-read memory model: data one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en_o) begin
            a_data_i <= mem_a[rd_addr_o];
            b_data_i <= mem_b[rd_addr_o];
        end
    end

    function automatic int gamma_of(input int i);
        int br = 0;
        int g  = 1;
        for (int j = 0; j < 7; j++) begin
            if (((i >> j) & 1) != 0) br = br | (1 << (6 - j));
        end
        for (int k = 0; k < 2 * br + 1; k++) begin
            g = (g * 17) % Q;
        end
        return g;
    endfunction

    function automatic logic [23:0] expect_pair(input logic [23:0] a, input logic [23:0] b,
                                                input int g);
        longint a0 = longint'(a[11:0]);
        longint a1 = longint'(a[23:12]);
        longint b0 = longint'(b[11:0]);
        longint b1 = longint'(b[23:12]);
        longint c0 = (a0 * b0 + a1 * b1 * longint'(g)) % Q;
        longint c1 = (a0 * b1 + a1 * b0) % Q;
        return {12'(c1), 12'(c0)};
    endfunction

    // Advance to the next falling edge and run the scoreboard on that cycle.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (wr_en_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write addr=%0d data=%h required=no_write",
                         wr_addr_o, wr_data_o);
            end else begin
                e = sb.pop_front();
                if ({wr_addr_o, wr_data_o} !== e) begin
                    errors++;
                    $display("FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h",
                             wr_addr_o, wr_data_o, e.addr, e.data);
                end
            end
        end
        if (rd_en_o) begin
            sb.push_back({rd_addr_o, expect_pair(mem_a[rd_addr_o], mem_b[rd_addr_o],
                                                 gamma_ref[rd_addr_o])});
        end
        if (rst) sb.delete();
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin mem_a[i] = {12'd0, 12'd1}; mem_b[i] = {12'(2 * i), 12'(i)}; end
                1: begin mem_a[i] = {12'd1, 12'd0}; mem_b[i] = {12'd1, 12'd0}; end
                2: begin mem_a[i] = {12'd3328, 12'd3328}; mem_b[i] = {12'd3328, 12'd3328}; end
                default: begin
                    mem_a[i] = {12'($urandom_range(Q - 1)), 12'($urandom_range(Q - 1))};
                    mem_b[i] = {12'($urandom_range(Q - 1)), 12'($urandom_range(Q - 1))};
                end
            endcase
        end
    endtask

    // Runs one job starting at the current falling edge (start sampled at T).
    // Step k observes cycle T+k. poke_k/rst_k (0 = unused) pulse start_i or
    // rst during cycle T+poke_k / T+rst_k.
    task automatic run_job(input string name, input int poke_k, input int rst_k);
        int first_wr = -1;
        int last_wr  = -1;
        int n_wr     = 0;
        int done_k   = -1;
        int n_done   = 0;
        bit gap      = 1'b0;
        bit busy_after = 1'b1;
        start_i = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (wr_en_o) begin
                if (n_wr == 0) first_wr = k;
                else if (k != last_wr + 1) gap = 1'b1;
                last_wr = k;
                n_wr++;
                c_out[wr_addr_o] = wr_data_o;
            end
            if (done_o) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (rst_k != 0 && k == rst_k + 1) begin
                checks++;
                if ({busy_o, done_o, rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, wr_data_o} !== '0) begin
                    errors++;
                    $display("FAIL %s_outputs_after_reset got busy=%b done=%b rd=%b wr=%b ra=%0d wa=%0d wd=%h required all 0",
                             name, busy_o, done_o, rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, wr_data_o);
                end
                return;
            end
            if (done_k >= 0 && k == done_k + 1) begin
                busy_after = busy_o;
                break;
            end
            if (k == 1 || k == poke_k) start_i = 1'b0;
            if (k == poke_k - 1) start_i = 1'b1;
            if (k == rst_k - 1) rst = 1'b1;
            if (k == rst_k) rst = 1'b0;
        end
        start_i = 1'b0;
        checks++;
        if (first_wr !== 6) begin
            errors++; $display("FAIL %s_first_write got T+%0d required T+6", name, first_wr);
        end
        checks++;
        if (last_wr !== 5 + N) begin
            errors++; $display("FAIL %s_last_write got T+%0d required T+%0d", name, last_wr, 5 + N);
        end
        checks++;
        if (n_wr !== N || gap) begin
            errors++; $display("FAIL %s_write_count got %0d gap=%0d required %0d contiguous", name, n_wr, gap, N);
        end
        checks++;
        if (done_k !== 6 + N) begin
            errors++; $display("FAIL %s_done_time got T+%0d required T+%0d", name, done_k, 6 + N);
        end
        checks++;
        if (n_done !== 1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse got pulses=%0d busy_after=%b required 1 and 0", name, n_done, busy_after);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL %s_sb_leftover got %0d required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        repeat (3) step();
        checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b required 0", busy_o); end
        checks++; if (done_o !== 1'b0)   begin errors++; $display("FAIL reset_done got %b required 0", done_o); end
        checks++; if (rd_en_o !== 1'b0)  begin errors++; $display("FAIL reset_rd_en got %b required 0", rd_en_o); end
        checks++; if (wr_en_o !== 1'b0)  begin errors++; $display("FAIL reset_wr_en got %b required 0", wr_en_o); end
        checks++; if (rd_addr_o !== '0)  begin errors++; $display("FAIL reset_rd_addr got %0d required 0", rd_addr_o); end
        checks++; if (wr_addr_o !== '0)  begin errors++; $display("FAIL reset_wr_addr got %0d required 0", wr_addr_o); end
        checks++; if (wr_data_o !== '0)  begin errors++; $display("FAIL reset_wr_data got %h required 0", wr_data_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_identity();
        fill(0);
        run_job("identity", 0, 0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (c_out[i] !== {12'(2 * i), 12'(i)}) begin
                errors++;
                $display("FAIL identity_c[%0d] got %h required %h", i, c_out[i], {12'(2 * i), 12'(i)});
            end
        end
    endtask

    task automatic test_gamma();
        fill(1);
        run_job("gamma", 0, 0);
        checks++;
        if (c_out[0] !== {12'd0, 12'd17}) begin
            errors++; $display("FAIL gamma_c0 got %h required %h", c_out[0], {12'd0, 12'd17});
        end
        checks++;
        if (c_out[1] !== {12'd0, 12'd3312}) begin
            errors++; $display("FAIL gamma_c1 got %h required %h", c_out[1], {12'd0, 12'd3312});
        end
        for (int i = 2; i < N; i++) begin
            checks++;
            if (c_out[i] !== {12'd0, 12'(gamma_ref[i])}) begin
                errors++; $display("FAIL gamma_c[%0d] got %h required %h", i, c_out[i], {12'd0, 12'(gamma_ref[i])});
            end
        end
    endtask

    task automatic test_max_operands();
        fill(2);
        run_job("max", 0, 0);
        checks++;
        if (c_out[0] !== {12'd2, 12'd18}) begin
            errors++; $display("FAIL max_c0 got %h required %h", c_out[0], {12'd2, 12'd18});
        end
        checks++;
        if (c_out[1] !== {12'd2, 12'd3313}) begin
            errors++; $display("FAIL max_c1 got %h required %h", c_out[1], {12'd2, 12'd3313});
        end
    endtask

    task automatic test_start_during_run();
        fill(3);
        run_job("start_mid", 50, 0);
    endtask

    task automatic test_mid_reset();
        int stray = 0;
        fill(3);
        run_job("reset_mid", 0, 70);
        for (int k = 0; k < 20; k++) begin
            step();
            if (wr_en_o || busy_o) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL reset_mid_quiet got %0d active cycles required 0", stray);
        end
        run_job("reset_restart", 0, 0);
    endtask

    task automatic test_back_to_back();
        fill(3);
        run_job("b2b_first", 0, 0);
        fill(3);
        run_job("b2b_second", 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < N; i++) gamma_ref[i] = gamma_of(i);
        test_reset();
        test_identity();
        test_gamma();
        test_max_operands();
        test_start_during_run();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
